// File: rtl/layer_mixer_pkg.sv
// Shared definitions for the layer mixer: display mode encodings, the default
// transparent key colour and a per-channel dimming helper.
package layer_mixer_pkg;

    typedef enum logic [1:0] {
        MODE_SPLASH = 2'd0,
        MODE_PLAY   = 2'd1,
        MODE_PAUSE  = 2'd2,
        MODE_END    = 2'd3
    } mode_e;

    localparam logic [11:0] KEY_COLOR_DEFAULT = 12'hF0F;

    // Widest pixel the dim helper handles; narrower pixels are zero-extended.
    localparam int unsigned MAX_RGB_W = 48;

    // Halve each channel of ch_w bits: shift right by one, clearing each channel MSB.
    function automatic logic [MAX_RGB_W-1:0] dim_rgb(input logic [MAX_RGB_W-1:0] rgb,
                                                     input int unsigned ch_w);
        logic [MAX_RGB_W-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < MAX_RGB_W - 1; i++) begin
            if ((i % ch_w) != (ch_w - 1)) begin
                res[i] = rgb[i+1];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/layer_mixer_prio_enc.sv
// Combinational priority encoder: lowest set request bit wins.
// Ports: req   - per-layer request vector (bit 0 highest priority)
//        idx   - winning index, NUM_LAYERS when nothing is requested
//        found - at least one request bit is set
module layer_prio_enc
    import layer_mixer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 8,
    parameter int unsigned IDX_W      = $clog2(NUM_LAYERS + 1)
) (
    input  logic [NUM_LAYERS-1:0] req,
    output logic [IDX_W-1:0]      idx,
    output logic                  found
);

    // Scan from the lowest priority upward so the last hit is the lowest index.
    always_comb begin
        idx   = IDX_W'(NUM_LAYERS);
        found = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_mixer.sv
// N-layer pixel compositor with frame-latched display mode and layer mask,
// frame-counted hit-flash and per-frame layer-0 overlap accumulation.
// Ports: clk/rst (async, active high); pix_valid, frame_start, layer_en,
//        layer_rgb, layer_mask, bg_rgb, splash_rgb, mode, flash_req in;
//        out_rgb, out_valid, hit_layer (2-cycle latency), collision_vec,
//        flashing out. All outputs are registered.
module layer_mixer
    import layer_mixer_pkg::*;
#(
    parameter int unsigned       NUM_LAYERS   = 8,
    parameter int unsigned       RGB_W        = 12,
    parameter logic [RGB_W-1:0]  KEY_COLOR    = RGB_W'(KEY_COLOR_DEFAULT),
    parameter int unsigned       FLASH_FRAMES = 6,
    parameter int unsigned       IDX_W        = $clog2(NUM_LAYERS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pix_valid,
    input  logic                        frame_start,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]       layer_mask,
    input  logic [RGB_W-1:0]            bg_rgb,
    input  logic [RGB_W-1:0]            splash_rgb,
    input  logic [1:0]                  mode,
    input  logic                        flash_req,
    output logic [RGB_W-1:0]            out_rgb,
    output logic                        out_valid,
    output logic [IDX_W-1:0]            hit_layer,
    output logic [NUM_LAYERS-1:0]       collision_vec,
    output logic                        flashing
);

    localparam int unsigned CH_W = RGB_W / 3;
    localparam int unsigned FC_W = $clog2(FLASH_FRAMES + 1);

    mode_e                 mode_q;
    logic [NUM_LAYERS-1:0] mask_q;
    logic [FC_W-1:0]       flash_cnt;
    logic [FC_W-1:0]       flash_nxt;
    logic [NUM_LAYERS-1:0] acc;

    logic [NUM_LAYERS-1:0] opaque_c;
    logic [IDX_W-1:0]      win_idx_c;
    logic                  win_found_c;
    logic [RGB_W-1:0]      win_rgb_c;

    logic                  s1_valid;
    logic [RGB_W-1:0]      s1_rgb;
    logic [IDX_W-1:0]      s1_idx;
    logic [NUM_LAYERS-1:0] s1_opaque;
    logic [RGB_W-1:0]      s1_splash;

    logic [NUM_LAYERS-1:0] hit_bits_c;
    logic [RGB_W-1:0]      out_rgb_d;
    logic [IDX_W-1:0]      hit_layer_d;

    // Opaque = covering, enabled by the latched mask, and not the key colour.
    always_comb begin
        opaque_c = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            opaque_c[k] = layer_en[k] && mask_q[k] &&
                          (layer_rgb[k*RGB_W +: RGB_W] != KEY_COLOR);
        end
    end

    layer_prio_enc #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (IDX_W)
    ) u_prio_enc (
        .req   (opaque_c),
        .idx   (win_idx_c),
        .found (win_found_c)
    );

    // Winner colour mux, background when no layer is opaque.
    always_comb begin
        win_rgb_c = bg_rgb;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (win_found_c && (win_idx_c == IDX_W'(k))) begin
                win_rgb_c = layer_rgb[k*RGB_W +: RGB_W];
            end
        end
    end

    // Stage 1 pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_rgb    <= '0;
            s1_idx    <= IDX_W'(NUM_LAYERS);
            s1_opaque <= '0;
            s1_splash <= '0;
        end else begin
            s1_valid  <= pix_valid;
            s1_rgb    <= win_rgb_c;
            s1_idx    <= win_idx_c;
            s1_opaque <= opaque_c;
            s1_splash <= splash_rgb;
        end
    end

    // Stage 2 mode mapping; blank output when no valid pixel is in flight.
    always_comb begin
        out_rgb_d   = '0;
        hit_layer_d = IDX_W'(NUM_LAYERS);
        if (s1_valid) begin
            case (mode_q)
                MODE_PLAY: begin
                    out_rgb_d   = ((flash_cnt != '0) && flash_cnt[0]) ? ~s1_rgb : s1_rgb;
                    hit_layer_d = s1_idx;
                end
                MODE_PAUSE: begin
                    out_rgb_d   = RGB_W'(dim_rgb(MAX_RGB_W'(s1_rgb), CH_W));
                    hit_layer_d = s1_idx;
                end
                default: begin
                    out_rgb_d   = s1_splash;
                    hit_layer_d = IDX_W'(NUM_LAYERS);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_rgb   <= '0;
            out_valid <= 1'b0;
            hit_layer <= IDX_W'(NUM_LAYERS);
        end else begin
            out_rgb   <= out_rgb_d;
            out_valid <= s1_valid;
            hit_layer <= hit_layer_d;
        end
    end

    // Frame-latched mode and mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_SPLASH;
            mask_q <= '1;
        end else if (frame_start) begin
            mode_q <= mode_e'(mode);
            mask_q <= layer_mask;
        end
    end

    // Flash counter: a request (re)loads and beats a same-cycle frame decrement.
    always_comb begin
        flash_nxt = flash_cnt;
        if (flash_req) begin
            flash_nxt = FC_W'(FLASH_FRAMES);
        end else if (frame_start && (flash_cnt != '0)) begin
            flash_nxt = flash_cnt - FC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_cnt <= '0;
            flashing  <= 1'b0;
        end else begin
            flash_cnt <= flash_nxt;
            flashing  <= (flash_nxt != '0);
        end
    end

    // Overlap of layer 0 with every other opaque layer, occluded or not.
    always_comb begin
        hit_bits_c = '0;
        if (s1_valid && s1_opaque[0]) begin
            hit_bits_c = {s1_opaque[NUM_LAYERS-1:1], 1'b0};
        end
    end

    // Publish at frame start; a same-cycle hit seeds the new frame's accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc           <= '0;
            collision_vec <= '0;
        end else if (frame_start) begin
            collision_vec <= acc;
            acc           <= hit_bits_c;
        end else begin
            acc           <= acc | hit_bits_c;
        end
    end

endmodule

// File: tb/tb_layer_mixer.sv
// Directed scoreboard bench for layer_mixer.
module tb_layer_mixer;

    localparam int unsigned NL = 8;
    localparam int unsigned RW = 12;

    logic           clk;
    logic           rst;
    logic           pix_valid;
    logic           frame_start;
    logic [NL-1:0]  layer_en;
    logic [NL*RW-1:0] layer_rgb;
    logic [NL-1:0]  layer_mask;
    logic [RW-1:0]  bg_rgb;
    logic [RW-1:0]  splash_rgb;
    logic [1:0]     mode;
    logic           flash_req;
    logic [RW-1:0]  out_rgb;
    logic           out_valid;
    logic [3:0]     hit_layer;
    logic [NL-1:0]  collision_vec;
    logic           flashing;

    layer_mixer dut (
        .clk           (clk),
        .rst           (rst),
        .pix_valid     (pix_valid),
        .frame_start   (frame_start),
        .layer_en      (layer_en),
        .layer_rgb     (layer_rgb),
        .layer_mask    (layer_mask),
        .bg_rgb        (bg_rgb),
        .splash_rgb    (splash_rgb),
        .mode          (mode),
        .flash_req     (flash_req),
        .out_rgb       (out_rgb),
        .out_valid     (out_valid),
        .hit_layer     (hit_layer),
        .collision_vec (collision_vec),
        .flashing      (flashing)
    );

    typedef struct {
        logic [11:0] rgb;
        logic [3:0]  idx;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    // Reference state
    logic [1:0]  mode_m;
    logic [7:0]  mask_m;
    logic [7:0]  model_acc;
    logic [7:0]  defer_acc;
    int          cnt_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid output must match the oldest pending pixel, 2 cycles on.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_checks++;
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_out: out_rgb=%h hit_layer=%0d with nothing pending",
                         out_rgb, hit_layer);
            end else begin
                mon_e = q.pop_front();
                if (out_rgb !== mon_e.rgb || hit_layer !== mon_e.idx || cyc != mon_e.cyc + 2) begin
                    n_errors++;
                    $display("FAIL pixel: got rgb=%h idx=%0d cyc=%0d, expected rgb=%h idx=%0d cyc=%0d",
                             out_rgb, hit_layer, cyc, mon_e.rgb, mon_e.idx, mon_e.cyc + 2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_l(input int k, input logic [11:0] v);
        layer_rgb[k*RW +: RW] = v;
    endtask

    // Issue one pixel and queue its expected composite.
    task automatic pix(input logic [7:0] en, input logic [11:0] bg,
                       input logic [11:0] spl, input bit defer);
        logic [7:0]  opq;
        logic [11:0] col;
        logic [11:0] er;
        logic [3:0]  ei;
        logic [7:0]  hb;
        layer_en   = en;
        bg_rgb     = bg;
        splash_rgb = spl;
        pix_valid  = 1'b1;
        for (int k = 0; k < 8; k++)
            opq[k] = en[k] && mask_m[k] && (layer_rgb[k*RW +: RW] != 12'hF0F);
        col = bg;
        ei  = 4'd8;
        for (int k = 7; k >= 0; k--) begin
            if (opq[k]) begin
                col = layer_rgb[k*RW +: RW];
                ei  = 4'(k);
            end
        end
        case (mode_m)
            2'd1: er = (cnt_m % 2 == 1) ? ~col : col;
            2'd2: er = {1'b0, col[11:9], 1'b0, col[7:5], 1'b0, col[3:1]};
            default: begin
                er = spl;
                ei = 4'd8;
            end
        endcase
        q.push_back('{er, ei, cyc});
        hb = opq[0] ? {opq[7:1], 1'b0} : 8'h00;
        if (defer) defer_acc = defer_acc | hb;
        else       model_acc = model_acc | hb;
        tick();
        pix_valid = 1'b0;
        layer_en  = '0;
    endtask

    // Frame boundary; no_gap puts it right behind the last pixel.
    task automatic frame(input bit no_gap);
        logic [7:0] coll_exp;
        if (!no_gap) tick();
        frame_start = 1'b1;
        coll_exp  = model_acc;
        model_acc = defer_acc;
        defer_acc = '0;
        mode_m    = mode;
        mask_m    = layer_mask;
        if (cnt_m > 0) cnt_m--;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        chk("collision_vec", 32'(collision_vec), 32'(coll_exp));
        chk("flashing", 32'(flashing), 32'(cnt_m != 0));
    endtask

    task automatic flash();
        flash_req = 1'b1;
        cnt_m     = 6;
        tick();
        flash_req = 1'b0;
        chk("flashing_set", 32'(flashing), 32'd1);
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; layer_en = '0;
        layer_rgb = '0; layer_mask = 8'hFF; bg_rgb = '0; splash_rgb = '0;
        mode = 2'd0; flash_req = 1'b0;
        mode_m = 2'd0; mask_m = 8'hFF; model_acc = '0; defer_acc = '0; cnt_m = 0;
        tick(); tick();
        chk("rst_out_rgb", 32'(out_rgb), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_hit_layer", 32'(hit_layer), 32'd8);
        chk("rst_collision", 32'(collision_vec), 32'h0);
        chk("rst_flashing", 32'(flashing), 32'h0);
        rst = 1'b0;
        tick();

        // Priority and transparency
        mode = 2'd1;
        frame(0);
        set_l(1, 12'h123); set_l(2, 12'h456);
        pix(8'b0000_0110, 12'h000, 12'h000, 0);
        set_l(1, 12'hF0F);
        pix(8'b0000_0110, 12'h000, 12'h000, 0);
        layer_mask[2] = 1'b0;
        pix(8'b0000_0110, 12'h0A0, 12'h000, 0);
        frame(0);
        pix(8'b0000_0110, 12'h0A0, 12'h000, 0);

        // Collisions, including occluded and same-cycle-as-frame_start hits
        layer_mask = 8'hFF;
        frame(0);
        set_l(0, 12'h111); set_l(3, 12'h333);
        pix(8'b0000_1011, 12'h000, 12'h000, 0);
        pix(8'b0000_1010, 12'h000, 12'h000, 0);
        frame(0);
        pix(8'b0000_0101, 12'h000, 12'h000, 1);
        frame(1);
        frame(0);
        frame(0);
        layer_mask = 8'b1111_1011;
        frame(0);
        pix(8'b0000_0101, 12'h000, 12'h000, 0);
        frame(0);
        layer_mask = 8'hFF;
        frame(0);

        // Hit-flash with restart
        set_l(0, 12'h0F0);
        flash();
        pix(8'b0000_0001, 12'h000, 12'h000, 0);
        for (int i = 0; i < 6; i++) begin
            frame(0);
            pix(8'b0000_0001, 12'h000, 12'h000, 0);
        end
        flash();
        for (int i = 0; i < 3; i++) begin
            frame(0);
            pix(8'b0000_0001, 12'h000, 12'h000, 0);
        end
        flash();
        for (int i = 0; i < 6; i++) begin
            frame(0);
            pix(8'b0000_0001, 12'h000, 12'h000, 0);
        end

        // Pause dim, end screen, mid-frame mode change
        mode = 2'd2;
        set_l(0, 12'hFA4);
        pix(8'b0000_0001, 12'h000, 12'h000, 0);
        frame(0);
        pix(8'b0000_0001, 12'h000, 12'h000, 0);
        mode = 2'd3;
        pix(8'b0000_0001, 12'h000, 12'h000, 0);
        frame(0);
        pix(8'b0000_0001, 12'h000, 12'h5C3, 0);
        pix(8'b0000_0001, 12'h000, 12'h3A1, 0);

        // Reset mid-frame while flashing with collisions pending
        mode = 2'd1;
        frame(0);
        set_l(0, 12'h111); set_l(1, 12'h222);
        pix(8'b0000_0011, 12'h000, 12'h000, 0);
        frame(0);
        pix(8'b0000_0011, 12'h000, 12'h000, 0);
        flash();
        pix(8'b0000_0011, 12'h000, 12'h000, 0);
        rst = 1'b1;
        #1;
        chk("midrst_out_rgb", 32'(out_rgb), 32'h0);
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_hit_layer", 32'(hit_layer), 32'd8);
        chk("midrst_collision", 32'(collision_vec), 32'h0);
        chk("midrst_flashing", 32'(flashing), 32'h0);
        q.delete();
        mode_m = 2'd0; mask_m = 8'hFF; model_acc = '0; defer_acc = '0; cnt_m = 0;
        tick();
        rst = 1'b0;
        tick();
        pix(8'b0000_0011, 12'h000, 12'h777, 0);
        frame(0);
        pix(8'b0000_0011, 12'h000, 12'h000, 0);

        // Drain with a bounded wait
        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        chk("drain_pending", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/layer_mixer.md
Name: layer_mixer

Overview:
- Parametrised N-layer pixel compositor placed between the sprite/judge blocks and the VGA driver. It replaces the fixed priority chain in the top level.
- Per pixel: picks the highest-priority enabled, non-transparent layer, otherwise the background.
- Applies a frame-latched display mode (splash, play, pause-dim, end) and a frame-counted hit-flash effect.
- Accumulates per-frame overlap flags between layer 0 (player plane) and every other layer, for use by the boom/health logic.

Parameters:
- NUM_LAYERS, 8, number of sprite layers; index 0 is highest priority; must be 2..16.
- RGB_W, 12, pixel colour width; 3 equal channels of RGB_W/3 bits.
- KEY_COLOR, 12'hF0F, colour treated as transparent on every layer.
- FLASH_FRAMES, 6, frames a hit-flash lasts.
- IDX_W, $clog2(NUM_LAYERS+1), width of the winner index.

Ports:
- clk  in  1  pixel clock (25.175 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- pix_valid  in  1  current pixel is in the active area.
- frame_start  in  1  one-cycle pulse at the start of each frame, during blanking.
- layer_en  in  NUM_LAYERS  per-layer "sprite covers this pixel".
- layer_rgb  in  NUM_LAYERS*RGB_W  per-layer colour; layer k occupies bits [k*RGB_W +: RGB_W].
- layer_mask  in  NUM_LAYERS  software layer enable; latched at frame_start.
- bg_rgb  in  RGB_W  background colour for the pixel.
- splash_rgb  in  RGB_W  start/end screen colour for the pixel.
- mode  in  2  requested mode: 0 SPLASH, 1 PLAY, 2 PAUSE, 3 END; latched at frame_start.
- flash_req  in  1  one-cycle pulse that starts or restarts the hit-flash.
- out_rgb  out  RGB_W  composited pixel.
- out_valid  out  1  pix_valid delayed by 2 cycles.
- hit_layer  out  IDX_W  winning layer index for out_rgb; the value NUM_LAYERS means background.
- collision_vec  out  NUM_LAYERS  overlap flags of layer 0 with each layer over the previous frame; bit 0 is always 0.
- flashing  out  1  flash counter is nonzero.

Behaviour:
- Reset values (asynchronous):
  - out_rgb=0, out_valid=0, hit_layer=NUM_LAYERS, collision_vec=0, flashing=0.
  - mode_q=SPLASH, mask_q=all ones, flash_cnt=0, collision accumulator=0.
- Opaque test: layer k is opaque when layer_en[k] and mask_q[k] and layer_rgb[k] != KEY_COLOR.
- Stage 1 (registered):
  - Winner = lowest opaque index; if none, winner = NUM_LAYERS and colour = bg_rgb.
  - Registers the winner colour, winner index, pix_valid, and the opaque vector.
- Stage 2 (registered): output mapping by mode_q.
  - SPLASH/END: out_rgb = splash_rgb; splash_rgb is delayed internally so it stays aligned with the pipeline. hit_layer = NUM_LAYERS.
  - PLAY: out_rgb = winner colour. It is bitwise inverted when flash_cnt != 0 and flash_cnt[0]=1, which gives a blink at frame rate.
  - PAUSE: each channel of the winner colour is shifted right by 1 (dim). No flash is applied.
  - When the stage-2 valid is low, out_rgb=0 and hit_layer=NUM_LAYERS.
- Latency is exactly 2 clocks from inputs to out_rgb/out_valid/hit_layer in every mode.
- Frame latching:
  - mode_q and mask_q load only on the frame_start cycle.
  - Mid-frame changes to mode or layer_mask have no effect until the next frame_start.
- Collision accumulator:
  - When the stage-1 valid is set and opaque[0]: acc[k] |= opaque[k] for k >= 1. Uses opaque, not the winner, so occluded overlaps still count.
  - On frame_start: collision_vec <= acc, and acc is cleared.
  - A hit in the same cycle as frame_start goes into the new acc, never into the vector being published.
  - Masked or keyed layers never collide.
- Flash counter:
  - flash_req loads flash_cnt = FLASH_FRAMES.
  - Otherwise, each frame_start decrements flash_cnt if it is nonzero; it saturates at 0.
  - flash_req and frame_start in the same cycle: the load wins.
  - flash_req while already counting restarts the count.
  - flashing = (flash_cnt != 0); it is set the cycle after flash_req.
- Pixel alignment: the caller supplies pixel inputs 2 cycles ahead of the VGA output.
- Reset mid-frame: all state clears immediately. Outputs stay blank until pix_valid propagates again; mode stays SPLASH until the first frame_start.

Decomposition:
- Package layer_mixer_pkg holds:
  - mode encodings (MODE_SPLASH/PLAY/PAUSE/END);
  - default KEY_COLOR;
  - a channel-dim helper function.
- Sub-module layer_prio_enc: parametrised NUM_LAYERS-input priority encoder. It is purely combinational and outputs the winner index and a found flag, instantiated in stage 1.
- All other logic lives in layer_mixer.

Test Plan:
- Priority: mode=PLAY, layer_en=8'b0000_0110, layer1=12'h123, layer2=12'h456, bg=12'h000. Expect out_rgb=12'h123, hit_layer=1, 2 cycles later.
- Transparency/mask:
  - layer1=12'hF0F (key), layer2=12'h456: expect 12'h456, hit_layer=2.
  - Then set layer_mask[2]=0 mid-frame: output unchanged until the next frame_start, then bg_rgb with hit_layer=8.
- Collision: layers 0 and 3 overlap on one pixel, with layer 1 covering both. After the next frame_start, collision_vec=8'b0000_1000. One frame later with no overlap, it returns to 0.
- Flash: flash_req in PLAY with winner 12'h0F0.
  - flashing=1 on the next cycle.
  - Output alternates 12'hF0F/12'h0F0 per frame over 6 frame_starts.
  - flashing=0 after the 6th frame_start.
  - A re-pulse at frame 3 extends the flash by 6 more frames.
- Modes:
  - mode=PAUSE, winner 12'hFA4: expect 12'h752.
  - mode=END: out_rgb=splash_rgb, hit_layer=8.
  - A mode change mid-frame takes effect only after frame_start.
- Reset: assert rst mid-frame while flashing and with collisions accumulated. Expect all outputs at reset values at once, SPLASH output after release, and collision_vec=0 after the first frame_start.
